multi_voice_sample_player: RTL
==============================

# multi_voice_sample_player

Polyphonic sample playback engine: up to VOICES independently triggered sounds read from one shared sample ROM, mixed with saturation and written to the audio codec FIFO through the `audio_out_allowed` / `write_audio_out` handshake. It replaces per-sound player instances, each with a private ROM and controller, with a single time-multiplexed ROM port and one mixer. It sits between the key/trigger logic and the audio codec interface.

## Interface
- VOICES, 6: number of independent voices (1..16).
- ADDR_W, 20: ROM address width.
- SAMPLE_W, 10: signed two's-complement ROM sample width.
- OUT_W, 10: signed mixed output width.
- clock  in  1: sole clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- play  in  VOICES: per-voice trigger; rising edge starts or restarts the voice.
- start_addr  in  VOICES*ADDR_W: voice i first sample at [i*ADDR_W +: ADDR_W].
- end_addr  in  VOICES*ADDR_W: voice i last sample (inclusive), same packing.
- loop_en  in  VOICES: per-voice loop select (port exists only with SAMPLE_LOOP_EN).
- audio_out_allowed  in  1: codec FIFO has space.
- rom_addr  out  ADDR_W: shared ROM read address, registered.
- rom_q  in  SAMPLE_W: ROM data, valid exactly one cycle after rom_addr.
- write_audio_out  out  1: one-cycle write strobe, qualifies audio_out.
- audio_out  out  OUT_W: mixed sample.
- clear_buffer  out  1: one-cycle pulse when the last active voice finishes.
- active  out  VOICES: voice currently playing.
- done  out  VOICES: one-cycle pulse when voice i passes its end_addr without looping.

## Operation
- Reset values: rom_addr=0, audio_out=0, write_audio_out=0, clear_buffer=0, active=0, done=0, all pointers 0, FSM in IDLE, play edge-detect registers 0. A play line held high through reset release does not trigger.
- Trigger: a rising edge on play[i] sets ptr[i]=start_addr[i] and active[i]=1 in any state and any cycle. This applies during playback too (retrigger). A trigger wins over a same-cycle pointer advance or end-of-sample event for that voice.
- FSM states:
  - IDLE: leaves to SCAN when audio_out_allowed=1 and |active=1. Otherwise holds.
  - SCAN: lasts VOICES+1 cycles. Cycle k<VOICES drives rom_addr=ptr[k]. Cycle k≥1 adds rom_q of voice k-1 into the accumulator, but only if that voice was active when its address was issued; otherwise it adds 0. The accumulator clears on SCAN entry. Then goes to WRITE.
  - WRITE: drives audio_out=sat(acc) and write_audio_out=1 for one cycle, then returns to IDLE.
- Pointer advance: after voice i's address is issued, if it was active:
  - ptr[i]<end_addr[i] (unsigned): ptr[i]+1.
  - Otherwise (end reached): active[i]=0 and done[i] pulses.
- start_addr>end_addr: the voice plays one sample (start_addr) and then ends.
- Arithmetic: accumulator width SAMPLE_W+clog2(VOICES), signed. Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. When OUT_W>SAMPLE_W+clog2(VOICES), the accumulator is sign-extended.
- clear_buffer: pulses in the cycle after active transitions from nonzero to all-zero through end events. A retrigger in that same cycle suppresses it.
- audio_out_allowed is sampled only in IDLE. A deassertion during SCAN/WRITE does not abort the frame.
- Reset mid-frame: immediate return to the reset values. The partial frame is discarded and nothing is written.

## Timing
- Frame latency: audio_out_allowed sampled high in IDLE → write_audio_out high VOICES+2 cycles later.
- Frame period: at least VOICES+3 cycles, one sample per frame.
- Trigger to first contributing fetch: first SCAN after the edge-detect cycle, i.e. play edge registered at edge N+1.
- done/active update in the cycle after the final address of that voice is issued.

## Configuration
- SAMPLE_LOOP_EN defined:
  - loop_en port present.
  - An end event with loop_en[i]=1 reloads ptr[i]=start_addr[i], keeps active[i]=1 and does not pulse done[i].
- SAMPLE_LOOP_EN undefined: port absent; every voice is one-shot.

## Structure
- Package sample_player_pkg:
  - FSM state enum (IDLE, SCAN, WRITE).
  - clog2 helper and ACC_W derivation.
  - Saturation function.
- Sub-module voice_channel, instantiated VOICES times. It holds:
  - play edge detect.
  - ptr and active registers.
  - End compare, loop reload, done pulse.
  - Advance enable from the top-level scan index.
- Top level holds the FSM, scan counter, ROM address mux, accumulator and output register.

## Test plan
- VOICES=2, voice0 start=0x10 end=0x12, ROM[a]=a; pulse play[0], hold audio_out_allowed=1 → three writes 0x10,0x11,0x12, then done[0] pulse, clear_buffer pulse, no further writes.
- Both voices active, ROM samples 300 and 400 with SAMPLE_W=OUT_W=10 → audio_out=511 (positive saturation); samples -300 and -400 → -512.
- Retrigger voice0 at its second sample → next write is ROM[start] again; done[0] does not pulse before the new pass completes.
- audio_out_allowed low for 20 cycles while active → no write_audio_out and pointers frozen; raise it → write after exactly VOICES+2 cycles.
- SAMPLE_LOOP_EN, loop_en[0]=1, start=5 end=6 → output 5,6,5,6… with active[0] held high and done[0] never pulsing.
- Assert reset in mid-SCAN → all outputs reset values immediately; no write; play held high through release does not start a voice.

Source files
------------

// File: rtl/sample_player_pkg.sv
// Shared types and helpers for the multi-voice sample player:
// frame FSM state encoding, accumulator width derivation and output saturation.
package sample_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Scan counter must reach VOICES (up to 16), so five bits always suffice.
    localparam int SCAN_CNT_W = 5;

    function automatic int clog2_int(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Enough headroom to sum every voice at full scale without wrapping.
    function automatic int acc_width(input int sample_w, input int voices);
        return sample_w + clog2_int(voices);
    endfunction

    // Clamp a sign-extended sum into the signed range of an out_w-bit result.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v,
                                                     input int out_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/voice_channel.sv
// One playback voice: trigger edge detect, sample pointer, active flag,
// end-of-sample handling (one-shot or loop reload) and the done pulse.
module voice_channel #(
    parameter int ADDR_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              loop_en,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              active,
    output logic              done,
    output logic              trig
);

    logic play_d;
    logic armed;
    logic at_end;

    // armed stays low for the first cycle after reset so a play line held
    // high across reset release is not mistaken for a rising edge.
    always_comb begin
        trig   = armed & play & ~play_d;
        at_end = !(ptr < end_addr);
    end

    // Trigger takes priority over the advance/end handling of the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            play_d <= 1'b0;
            armed  <= 1'b0;
            ptr    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            play_d <= play;
            armed  <= 1'b1;
            done   <= 1'b0;
            if (trig) begin
                ptr    <= start_addr;
                active <= 1'b1;
            end else if (advance && active) begin
                if (!at_end) begin
                    ptr <= ptr + 1'b1;
                end else if (loop_en) begin
                    ptr <= start_addr;
                end else begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_voice_sample_player.sv
// Polyphonic sample player: VOICES voices share one ROM port, fetched in
// turn once per frame, summed with saturation and pushed to the codec FIFO.
// Build option: define SAMPLE_LOOP_EN to add the loop_en port and per-voice
// looping; without it every voice is one-shot.
//
// state | meaning
// IDLE  | wait for FIFO space while at least one voice is active
// SCAN  | VOICES+1 cycles: issue one ROM address per voice, accumulate data
// WRITE | present the saturated mix with a one-cycle write strobe
import sample_player_pkg::*;

module multi_voice_sample_player #(
    parameter int VOICES   = 6,
    parameter int ADDR_W   = 20,
    parameter int SAMPLE_W = 10,
    parameter int OUT_W    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [VOICES-1:0]        play,
    input  logic [VOICES*ADDR_W-1:0] start_addr,
    input  logic [VOICES*ADDR_W-1:0] end_addr,
`ifdef SAMPLE_LOOP_EN
    input  logic [VOICES-1:0]        loop_en,
`endif
    input  logic                     audio_out_allowed,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_q,
    output logic                     write_audio_out,
    output logic [OUT_W-1:0]         audio_out,
    output logic                     clear_buffer,
    output logic [VOICES-1:0]        active,
    output logic [VOICES-1:0]        done
);

    localparam int ACC_W = acc_width(SAMPLE_W, VOICES);
    localparam logic [SCAN_CNT_W-1:0] SCAN_LAST = SCAN_CNT_W'(VOICES);

    state_t                  state;
    logic [SCAN_CNT_W-1:0]   scan_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] add_term;
    logic                    addr_act;
    logic                    q_act;
    logic                    had_active;

    logic [ADDR_W-1:0]       ptr [VOICES];
    logic [VOICES-1:0]       trig;
    logic [VOICES-1:0]       adv;
    logic [VOICES-1:0]       loop_bits;

    logic                    go;
    logic                    issue_valid;
    logic [SCAN_CNT_W-1:0]   issue_idx;
    logic [ADDR_W-1:0]       issue_ptr;
    logic                    issue_act;

`ifdef SAMPLE_LOOP_EN
    assign loop_bits = loop_en;
`else
    assign loop_bits = '0;
`endif

    genvar g;
    generate
        for (g = 0; g < VOICES; g++) begin : g_voice
            voice_channel #(.ADDR_W(ADDR_W)) u_voice (
                .clock      (clock),
                .reset      (reset),
                .play       (play[g]),
                .start_addr (start_addr[g*ADDR_W +: ADDR_W]),
                .end_addr   (end_addr[g*ADDR_W +: ADDR_W]),
                .loop_en    (loop_bits[g]),
                .advance    (adv[g]),
                .ptr        (ptr[g]),
                .active     (active[g]),
                .done       (done[g]),
                .trig       (trig[g])
            );
        end
    endgenerate

    // Pick the voice whose address goes out at the next edge; that voice
    // advances on the same edge so a retrigger can never be skipped over.
    always_comb begin
        go          = (state == IDLE) && audio_out_allowed && (|active);
        issue_valid = go || ((state == SCAN) && ((scan_cnt + 1'b1) < SCAN_LAST));
        issue_idx   = go ? '0 : scan_cnt + 1'b1;
        issue_ptr   = '0;
        issue_act   = 1'b0;
        adv         = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (issue_idx == SCAN_CNT_W'(i)) begin
                issue_ptr = ptr[i];
                issue_act = active[i];
                adv[i]    = issue_valid;
            end
        end
        add_term = '0;
        if ((state == SCAN) && (scan_cnt != '0) && q_act)
            add_term = ACC_W'($signed(rom_q));
        acc_next = acc + add_term;
    end

    // Frame FSM with registered ROM address, accumulator and codec outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            scan_cnt        <= '0;
            acc             <= '0;
            rom_addr        <= '0;
            addr_act        <= 1'b0;
            q_act           <= 1'b0;
            audio_out       <= '0;
            write_audio_out <= 1'b0;
        end else begin
            write_audio_out <= 1'b0;
            q_act           <= addr_act;
            if (issue_valid) begin
                rom_addr <= issue_ptr;
                addr_act <= issue_act;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= SCAN;
                        scan_cnt <= '0;
                        acc      <= '0;
                    end
                end
                SCAN: begin
                    acc      <= acc_next;
                    scan_cnt <= scan_cnt + 1'b1;
                    if (scan_cnt == SCAN_LAST) begin
                        state           <= WRITE;
                        audio_out       <= OUT_W'(sat_clamp(32'(acc_next), OUT_W));
                        write_audio_out <= 1'b1;
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Flag the codec buffer flush once the last voice has run out; a new
    // trigger arriving in that cycle means playback continues, so no flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            had_active   <= 1'b0;
            clear_buffer <= 1'b0;
        end else begin
            had_active   <= |active;
            clear_buffer <= had_active && !(|active) && !(|trig);
        end
    end

endmodule
